// File: rtl/forward_exec_datapath_pkg.sv
// Shared constants for the execute-side forwarding datapath.
package forward_exec_datapath_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FWD_SEL_W  = 2;
  localparam int unsigned STAT_W     = 16;

  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  // Operand source selects: register file or one of the three history slots
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_EX  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_WB  = 2'b11;

  // mem_rw encoding
  localparam logic MEM_STORE = 1'b1;
  localparam logic MEM_LOAD  = 1'b0;

endpackage

// File: rtl/forward_exec_datapath_fwd_operand_mux.sv
// 4:1 operand source select between register file and result history.
module fwd_operand_mux
  import forward_exec_datapath_pkg::*;
#(
  parameter int unsigned W = DATA_W_DEF
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] rf,
  input  logic [W-1:0] ex_res,
  input  logic [W-1:0] mem_res,
  input  logic [W-1:0] wb_res,
  output logic [W-1:0] operand_c
);

  // Pick the operand source; history inputs are all registered upstream
  always_comb begin
    operand_c = rf;
    case (sel)
      FWD_EX:  operand_c = ex_res;
      FWD_MEM: operand_c = mem_res;
      FWD_WB:  operand_c = wb_res;
      default: operand_c = rf;
    endcase
  end

endmodule

// File: rtl/forward_exec_datapath.sv
// Execute/memory/write-back datapath with 3-deep result history for forwarding.
// Optional macro FWD_STATS_EN adds saturating forwarded-operand counters.
module forward_exec_datapath
  import forward_exec_datapath_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DM_ADDR_W  = 8,
  parameter int unsigned IMM_SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OP_W-1:0]       op_dec,
  input  logic [IMM_W-1:0]      imm,
  input  logic                  imm_sel,
  input  logic [1:0]            mux_sel_A,
  input  logic [1:0]            mux_sel_B,
  input  logic [DATA_W-1:0]     rf_a,
  input  logic [DATA_W-1:0]     rf_b,
  input  logic                  mem_en_ex,
  input  logic                  mem_rw_ex,
  input  logic                  mem_mux_sel_dm,
  input  logic [REG_ADDR_W-1:0] RW_dm,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [OP_W-1:0]       alu_op,
  input  logic [DATA_W-1:0]     alu_res,
  output logic                  dm_en,
  output logic                  dm_we,
  output logic [DM_ADDR_W-1:0]  dm_addr,
  output logic [DATA_W-1:0]     dm_wdata,
  input  logic [DATA_W-1:0]     dm_rdata,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data
`ifdef FWD_STATS_EN
  ,
  output logic [STAT_W-1:0]     fwd_cnt_a,
  output logic [STAT_W-1:0]     fwd_cnt_b
`endif
);

  logic [DATA_W-1:0] imm_ext_c;
  logic [DATA_W-1:0] sel_a_c;
  logic [DATA_W-1:0] sel_b_c;
  logic [DATA_W-1:0] st_b_q;
  logic [DATA_W-1:0] ex_res_q;
  logic [DATA_W-1:0] st_q;
  logic [DATA_W-1:0] mem_res_q;
  logic [DATA_W-1:0] wb_res_q;
  logic              men_q;
  logic              mrw_q;
  logic              dsel_q;
  logic              wbv_q;

  // Immediate widening to the datapath width
  generate
    if (DATA_W > IMM_W) begin : g_imm_ext
      logic ext_bit_c;
      assign ext_bit_c = (IMM_SIGNED != 0) ? imm[IMM_W-1] : 1'b0;
      assign imm_ext_c = {{(DATA_W-IMM_W){ext_bit_c}}, imm};
    end else begin : g_imm_fit
      assign imm_ext_c = imm[DATA_W-1:0];
    end
  endgenerate

  fwd_operand_mux #(.W(DATA_W)) u_mux_a (
    .sel       (mux_sel_A),
    .rf        (rf_a),
    .ex_res    (ex_res_q),
    .mem_res   (mem_res_q),
    .wb_res    (wb_res_q),
    .operand_c (sel_a_c)
  );

  fwd_operand_mux #(.W(DATA_W)) u_mux_b (
    .sel       (mux_sel_B),
    .rf        (rf_b),
    .ex_res    (ex_res_q),
    .mem_res   (mem_res_q),
    .wb_res    (wb_res_q),
    .operand_c (sel_b_c)
  );

  // OF -> EX: latch ALU operands; store data keeps the forwarded B even with imm
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      st_b_q <= '0;
    end else begin
      alu_a  <= sel_a_c;
      alu_b  <= imm_sel ? imm_ext_c : sel_b_c;
      alu_op <= op_dec;
      st_b_q <= sel_b_c;
    end
  end

  // EX -> MEM: capture ALU result and memory controls
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_res_q <= '0;
      st_q     <= '0;
      men_q    <= 1'b0;
      mrw_q    <= 1'b0;
    end else begin
      ex_res_q <= alu_res;
      st_q     <= st_b_q;
      men_q    <= mem_en_ex;
      mrw_q    <= mem_rw_ex;
    end
  end

  // MEM -> WB: stores are marked as not writing back
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_res_q <= '0;
      dsel_q    <= 1'b0;
      wb_addr   <= '0;
      wbv_q     <= 1'b0;
    end else begin
      mem_res_q <= ex_res_q;
      dsel_q    <= mem_mux_sel_dm;
      wb_addr   <= RW_dm;
      wbv_q     <= ~(men_q & (mrw_q == MEM_STORE));
    end
  end

  // Oldest history slot: whatever was written back last cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_res_q <= '0;
    end else begin
      wb_res_q <= wb_data;
    end
  end

  // Write-back value selection; load data arrives one cycle after dm_en
  always_comb begin
    wb_data = dsel_q ? dm_rdata : mem_res_q;
  end

  // Memory port and write enable decode
  always_comb begin
    dm_en    = men_q;
    dm_we    = men_q & (mrw_q == MEM_STORE);
    dm_addr  = ex_res_q[DM_ADDR_W-1:0];
    dm_wdata = st_q;
    wb_en    = wbv_q & (wb_addr != '0);
  end

`ifdef FWD_STATS_EN
  // Saturating counts of cycles with a forwarded operand select
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt_a <= '0;
      fwd_cnt_b <= '0;
    end else begin
      if ((mux_sel_A != FWD_RF) && (fwd_cnt_a != '1)) begin
        fwd_cnt_a <= fwd_cnt_a + STAT_W'(1);
      end
      if ((mux_sel_B != FWD_RF) && (fwd_cnt_b != '1)) begin
        fwd_cnt_b <= fwd_cnt_b + STAT_W'(1);
      end
    end
  end
`else
  // Forwarding statistics not built
`endif

endmodule

// File: tb/tb_forward_exec_datapath.sv
// Directed bench for forward_exec_datapath with an instruction-level model.
module tb_forward_exec_datapath;
  import forward_exec_datapath_pkg::*;

  localparam int N = 30;

  typedef struct packed {
    logic [5:0]  op;
    logic [15:0] imm;
    logic        isel;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [15:0] rfa;
    logic [15:0] rfb;
    logic        men;
    logic        mrw;
    logic        dsel;
    logic [4:0]  rw;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op_dec;
  logic [15:0] imm;
  logic        imm_sel;
  logic [1:0]  mux_sel_A, mux_sel_B;
  logic [15:0] rf_a, rf_b;
  logic        mem_en_ex, mem_rw_ex, mem_mux_sel_dm;
  logic [4:0]  RW_dm;
  logic [15:0] alu_a, alu_b, alu_res;
  logic [5:0]  alu_op;
  logic        dm_en, dm_we;
  logic [7:0]  dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata = 16'h0;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [15:0] wb_data;
`ifdef FWD_STATS_EN
  logic [15:0] fwd_cnt_a, fwd_cnt_b;
`endif

  instr_t      prog    [N];
  logic        rst_tab [N];
  logic [15:0] m_opa [N];
  logic [15:0] m_opb [N];
  logic [15:0] m_stb [N];
  logic [15:0] m_alu [N];
  logic [15:0] m_wbv [N];
  logic [15:0] mmem  [256];
  logic [15:0] envmem [256];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  forward_exec_datapath dut (
    .clk            (clk),
    .reset          (reset),
    .op_dec         (op_dec),
    .imm            (imm),
    .imm_sel        (imm_sel),
    .mux_sel_A      (mux_sel_A),
    .mux_sel_B      (mux_sel_B),
    .rf_a           (rf_a),
    .rf_b           (rf_b),
    .mem_en_ex      (mem_en_ex),
    .mem_rw_ex      (mem_rw_ex),
    .mem_mux_sel_dm (mem_mux_sel_dm),
    .RW_dm          (RW_dm),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op         (alu_op),
    .alu_res        (alu_res),
    .dm_en          (dm_en),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_rdata       (dm_rdata),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data)
`ifdef FWD_STATS_EN
    ,
    .fwd_cnt_a      (fwd_cnt_a),
    .fwd_cnt_b      (fwd_cnt_b)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External ALU: small opcode set
  function automatic logic [15:0] alu_f(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      6'd1:    return a - b;
      6'd2:    return a & b;
      6'd3:    return a | b;
      6'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  assign alu_res = alu_f(alu_op, alu_a, alu_b);

  // External data memory, registered read
  initial for (int k = 0; k < 256; k++) envmem[k] = 16'h0;
  always @(posedge clk) begin
    if (dm_en && dm_we) envmem[dm_addr] <= dm_wdata;
    if (dm_en && !dm_we) dm_rdata <= envmem[dm_addr];
  end

  // Instruction issued at cycle j is lost if reset appears at any cycle j..n-1
  function automatic bit flushed(input int j, input int n);
    if (j < 0) return 1'b1;
    for (int c = j; c < n; c++) if (rst_tab[c]) return 1'b1;
    return 1'b0;
  endfunction

  // Operand value: sel k refers to the instruction issued k+1 slots earlier
  function automatic logic [15:0] src(input int i, input logic [1:0] s, input logic [15:0] rf);
    int j;
    if (s == 2'b00) return rf;
    j = i - (int'(s) + 1);
    if (flushed(j, i)) return 16'h0;
    return (s == 2'b11) ? m_wbv[j] : m_alu[j];
  endfunction

  function automatic instr_t mk(input logic [5:0] op, input logic [1:0] sa, input logic [15:0] rfa,
                                input logic [1:0] sb, input logic [15:0] rfb, input logic [4:0] rw);
    instr_t t;
    t = '0;
    t.op = op; t.sa = sa; t.rfa = rfa; t.sb = sb; t.rfb = rfb; t.rw = rw;
    return t;
  endfunction

  task automatic build_prog();
    for (int c = 0; c < N; c++) begin prog[c] = '0; rst_tab[c] = 1'b0; end
    rst_tab[0] = 1'b1; rst_tab[1] = 1'b1;
    prog[2]  = mk(6'd0, 2'b00, 16'h0003, 2'b00, 16'h0004, 5'd5);
    prog[3]  = mk(6'd0, 2'b00, 16'h0005, 2'b00, 16'h0006, 5'd1);
    prog[5]  = mk(6'd0, 2'b01, 16'h0000, 2'b00, 16'h0001, 5'd2);
    prog[6]  = mk(6'd1, 2'b10, 16'h0000, 2'b00, 16'h0002, 5'd3);
    prog[7]  = mk(6'd4, 2'b11, 16'h0000, 2'b01, 16'h0000, 5'd4);
    prog[8]  = mk(6'd2, 2'b01, 16'h0000, 2'b10, 16'h0000, 5'd6);
    prog[9]  = mk(6'd0, 2'b00, 16'h0010, 2'b00, 16'hBEEF, 5'd7);
    prog[9].isel = 1'b1; prog[9].men = 1'b1; prog[9].mrw = MEM_STORE;
    prog[11] = mk(6'd0, 2'b00, 16'h0010, 2'b00, 16'h0000, 5'd8);
    prog[11].isel = 1'b1; prog[11].men = 1'b1; prog[11].mrw = MEM_LOAD; prog[11].dsel = 1'b1;
    prog[12] = mk(6'd0, 2'b00, 16'h0001, 2'b11, 16'h0000, 5'd9);
    prog[12].isel = 1'b1; prog[12].imm = 16'hFFFE; prog[12].men = 1'b1; prog[12].mrw = MEM_STORE;
    prog[13] = mk(6'd0, 2'b00, 16'h0007, 2'b00, 16'h0001, 5'd0);
    prog[14] = mk(6'd0, 2'b01, 16'h0000, 2'b00, 16'h0001, 5'd10);
    prog[15] = mk(6'd0, 2'b11, 16'h0000, 2'b00, 16'h0002, 5'd11);
    prog[16] = mk(6'd0, 2'b10, 16'h0000, 2'b00, 16'h0003, 5'd12);
    prog[17] = mk(6'd0, 2'b00, 16'h0021, 2'b00, 16'h0001, 5'd13);
    prog[18] = mk(6'd0, 2'b00, 16'h0020, 2'b00, 16'h0055, 5'd14);
    prog[18].isel = 1'b1; prog[18].men = 1'b1; prog[18].mrw = MEM_STORE;
    rst_tab[19] = 1'b1; rst_tab[20] = 1'b1;
    prog[21] = mk(6'd0, 2'b11, 16'h0000, 2'b00, 16'h0030, 5'd0);
    prog[22] = mk(6'd0, 2'b10, 16'h0000, 2'b00, 16'h0000, 5'd0);
    prog[23] = mk(6'd0, 2'b01, 16'h0000, 2'b00, 16'h0005, 5'd14);
  endtask

  // Instruction-level results in program order, with a memory array for loads
  task automatic build_model();
    logic [15:0] ld;
    for (int k = 0; k < 256; k++) mmem[k] = 16'h0;
    for (int i = 0; i < N; i++) begin
      if (rst_tab[i]) begin
        m_opa[i] = 16'h0; m_opb[i] = 16'h0; m_stb[i] = 16'h0; m_alu[i] = 16'h0; m_wbv[i] = 16'h0;
      end else begin
        m_opa[i] = src(i, prog[i].sa, prog[i].rfa);
        m_stb[i] = src(i, prog[i].sb, prog[i].rfb);
        m_opb[i] = prog[i].isel ? prog[i].imm : m_stb[i];
        m_alu[i] = alu_f(prog[i].op, m_opa[i], m_opb[i]);
        ld = 16'h0;
        if (prog[i].men && !flushed(i, i + 2)) begin
          if (prog[i].mrw == MEM_STORE) mmem[m_alu[i][7:0]] = m_stb[i];
          else ld = mmem[m_alu[i][7:0]];
        end
        m_wbv[i] = prog[i].dsel ? ld : m_alu[i];
      end
    end
  endtask

  // Present each instruction's fields in their own stages; flushed ones become bubbles
  task automatic drive(input int c);
    int j1, j2;
    reset     = rst_tab[c];
    op_dec    = prog[c].op;
    imm       = prog[c].imm;
    imm_sel   = prog[c].isel;
    mux_sel_A = prog[c].sa;
    mux_sel_B = prog[c].sb;
    rf_a      = prog[c].rfa;
    rf_b      = prog[c].rfb;
    j1 = c - 1;
    j2 = c - 2;
    mem_en_ex = 1'b0; mem_rw_ex = 1'b0; mem_mux_sel_dm = 1'b0; RW_dm = 5'd0;
    if (!flushed(j1, c + 1)) begin
      mem_en_ex = prog[j1].men;
      mem_rw_ex = prog[j1].mrw;
    end
    if (!flushed(j2, c + 1)) begin
      mem_mux_sel_dm = prog[j2].dsel;
      RW_dm          = prog[j2].rw;
    end
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  // Per-cycle comparison against the model plus fixed hand-computed points
  task automatic check_cycle(input int n);
    int i, jd, jw;
    logic [15:0] e_a, e_b, e_wd, e_dwd;
    logic [5:0]  e_op;
    logic        e_den, e_dwe, e_wen;
    logic [7:0]  e_dad;
    logic [4:0]  e_wad;
    i = n - 1; jd = n - 2; jw = n - 3;
    e_a = 16'h0; e_b = 16'h0; e_op = 6'h0;
    if (!rst_tab[i]) begin e_a = m_opa[i]; e_b = m_opb[i]; e_op = prog[i].op; end
    e_den = 1'b0; e_dwe = 1'b0; e_dad = 8'h0; e_dwd = 16'h0;
    if (!flushed(jd, n)) begin
      e_den = prog[jd].men;
      e_dwe = prog[jd].men & (prog[jd].mrw == MEM_STORE);
      e_dad = m_alu[jd][7:0];
      e_dwd = m_stb[jd];
    end
    e_wen = 1'b0; e_wad = 5'd0; e_wd = 16'h0;
    if (!flushed(jw, n)) begin
      e_wad = prog[jw].rw;
      e_wd  = m_wbv[jw];
      e_wen = !(prog[jw].men && prog[jw].mrw == MEM_STORE) && (prog[jw].rw != 5'd0);
    end
    chk("alu_a", n, 32'(alu_a), 32'(e_a));
    chk("alu_b", n, 32'(alu_b), 32'(e_b));
    chk("alu_op", n, 32'(alu_op), 32'(e_op));
    chk("dm_en", n, 32'(dm_en), 32'(e_den));
    chk("dm_we", n, 32'(dm_we), 32'(e_dwe));
    chk("dm_addr", n, 32'(dm_addr), 32'(e_dad));
    chk("dm_wdata", n, 32'(dm_wdata), 32'(e_dwd));
    chk("wb_en", n, 32'(wb_en), 32'(e_wen));
    chk("wb_addr", n, 32'(wb_addr), 32'(e_wad));
    chk("wb_data", n, 32'(wb_data), 32'(e_wd));
`ifdef FWD_STATS_EN
    begin
      int ca, cb;
      ca = 0; cb = 0;
      for (int c = 0; c < n; c++) begin
        if (rst_tab[c]) begin ca = 0; cb = 0; end
        else begin
          if (prog[c].sa != 2'b00 && ca < 65535) ca++;
          if (prog[c].sb != 2'b00 && cb < 65535) cb++;
        end
      end
      chk("fwd_cnt_a", n, 32'(fwd_cnt_a), 32'(ca));
      chk("fwd_cnt_b", n, 32'(fwd_cnt_b), 32'(cb));
      if (n == 24) chk("lit_fwd_cnt_a_3", n, 32'(fwd_cnt_a), 32'd3);
    end
`endif
    case (n)
      1: begin
        chk("lit_rst_alu_a", n, 32'(alu_a), 32'h0);
        chk("lit_rst_alu_op", n, 32'(alu_op), 32'h0);
        chk("lit_rst_dm_en", n, 32'(dm_en), 32'h0);
        chk("lit_rst_wb_data", n, 32'(wb_data), 32'h0);
      end
      3: begin
        chk("lit_sel00_a", n, 32'(alu_a), 32'h3);
        chk("lit_sel00_b", n, 32'(alu_b), 32'h4);
      end
      5: begin
        chk("lit_wb_7", n, 32'(wb_data), 32'h7);
        chk("lit_wb_addr5", n, 32'(wb_addr), 32'h5);
        chk("lit_wb_en", n, 32'(wb_en), 32'h1);
      end
      6: chk("lit_fwd01", n, 32'(alu_a), 32'h000B);
      7: chk("lit_fwd10", n, 32'(alu_a), 32'h000B);
      8: begin
        chk("lit_fwd11", n, 32'(alu_a), 32'h000B);
        chk("lit_fwd01_b", n, 32'(alu_b), 32'h000C);
      end
      11: begin
        chk("lit_st_we", n, 32'(dm_we), 32'h1);
        chk("lit_st_addr", n, 32'(dm_addr), 32'h10);
        chk("lit_st_data", n, 32'(dm_wdata), 32'hBEEF);
      end
      12: chk("lit_st_no_wb", n, 32'(wb_en), 32'h0);
      13: chk("lit_imm_b", n, 32'(alu_b), 32'hFFFE);
      14: begin
        chk("lit_ld_data", n, 32'(wb_data), 32'hBEEF);
        chk("lit_ld_wb_en", n, 32'(wb_en), 32'h1);
        chk("lit_imm_st_data", n, 32'(dm_wdata), 32'h0008);
      end
      16: begin
        chk("lit_r0_no_wb", n, 32'(wb_en), 32'h0);
        chk("lit_fwd11_load", n, 32'(alu_a), 32'hBEEF);
      end
      20, 21: begin
        chk("lit_mid_rst_alu_a", n, 32'(alu_a), 32'h0);
        chk("lit_mid_rst_dm_en", n, 32'(dm_en), 32'h0);
        chk("lit_mid_rst_wb_en", n, 32'(wb_en), 32'h0);
      end
      22: begin
        chk("lit_post_rst_wb_en", n, 32'(wb_en), 32'h0);
        chk("lit_hist_cleared", n, 32'(alu_a), 32'h0);
      end
      23: chk("lit_post_rst_wb_en", n, 32'(wb_en), 32'h0);
      24: begin
        chk("lit_post_rst_wb_en", n, 32'(wb_en), 32'h0);
        chk("lit_post_rst_fwd", n, 32'(alu_a), 32'h0030);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < N) check_cycle(cyc);
  end

  initial begin
    build_prog();
    build_model();
    drive(0);
    for (int c = 1; c < N; c++) begin
      @(posedge clk);
      #1;
      drive(c);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
